// File: rtl/amp_adc_reader_if.sv
// SPI read path between the ADC reader and the dual-channel ADC.
// The master side generates SCK and the conversion trigger and samples MISO.
interface amp_adc_reader_if;
    logic SPI_SCK;
    logic SPI_MISO;
    logic AD_CONV;

    modport master (
        output SPI_SCK,
        output AD_CONV,
        input  SPI_MISO
    );

    modport slave (
        input  SPI_SCK,
        input  AD_CONV,
        output SPI_MISO
    );
endinterface

// File: rtl/amp_adc_reader.sv
// Dual-channel 14-bit ADC reader: one AD_CONV pulse plus a 34-bit SPI read per
// frame. Both samples are presented with a one-cycle data_valid strobe.
module amp_adc_reader #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned FRAME_BITS = 34
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic                    start,
    amp_adc_reader_if.master        spi,
    output logic                    busy,
    output logic [13:0]             ch0_data,
    output logic [13:0]             ch1_data,
    output logic                    data_valid
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CntW = $clog2(FRAME_BITS);

    localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] LastBit  = CntW'(FRAME_BITS - 1);
    // Sample windows inside the frame; the remaining counts are ADC hi-Z bits.
    localparam logic [CntW-1:0] Ch0First = CntW'(2);
    localparam logic [CntW-1:0] Ch0Last  = CntW'(15);
    localparam logic [CntW-1:0] Ch1First = CntW'(18);
    localparam logic [CntW-1:0] Ch1Last  = CntW'(31);

    typedef enum logic [1:0] {StIdle, StConv, StShift} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic            sck_q, sck_d;
    logic            conv_q, conv_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [13:0]     sh0_q, sh0_d;
    logic [13:0]     sh1_q, sh1_d;
    logic [13:0]     ch0_q, ch0_d;
    logic [13:0]     ch1_q, ch1_d;
    logic            dv_q, dv_d;

    logic tick;
    logic fall_tick;

    assign tick      = (div_q == DivLast);
    // SCK is high just before a falling tick, so the tick takes it low.
    assign fall_tick = tick && sck_q;

    // State register.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: CONV lasts one SCK period, SHIFT ends on the last fall.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StConv;
            StConv:  if (fall_tick) state_d = StShift;
            StShift: if (fall_tick && (bit_cnt_q == LastBit)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state: divider, SCK, shift registers, capture.
    always_comb begin
        div_d     = '0;
        sck_d     = 1'b0;
        conv_d    = (state_d == StConv);
        bit_cnt_d = bit_cnt_q;
        sh0_d     = sh0_q;
        sh1_d     = sh1_q;
        ch0_d     = ch0_q;
        ch1_d     = ch1_q;
        dv_d      = 1'b0;

        if (state_q != StIdle) begin
            div_d = tick ? '0 : div_q + 1'b1;
            sck_d = tick ? ~sck_q : sck_q;
        end

        if ((state_q == StConv) && fall_tick) begin
            bit_cnt_d = '0;
        end

        if ((state_q == StShift) && fall_tick) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if ((bit_cnt_q >= Ch0First) && (bit_cnt_q <= Ch0Last)) begin
                sh0_d = {sh0_q[12:0], spi.SPI_MISO};
            end
            if ((bit_cnt_q >= Ch1First) && (bit_cnt_q <= Ch1Last)) begin
                sh1_d = {sh1_q[12:0], spi.SPI_MISO};
            end
            if (bit_cnt_q == LastBit) begin
                ch0_d     = sh0_q;
                ch1_d     = sh1_q;
                dv_d      = 1'b1;
                bit_cnt_d = '0;
            end
        end
    end

    // Datapath registers; reset aborts any frame and clears captured data.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            div_q     <= '0;
            sck_q     <= 1'b0;
            conv_q    <= 1'b0;
            bit_cnt_q <= '0;
            sh0_q     <= '0;
            sh1_q     <= '0;
            ch0_q     <= '0;
            ch1_q     <= '0;
            dv_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            sck_q     <= sck_d;
            conv_q    <= conv_d;
            bit_cnt_q <= bit_cnt_d;
            sh0_q     <= sh0_d;
            sh1_q     <= sh1_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
            dv_q      <= dv_d;
        end
    end

    assign spi.SPI_SCK = sck_q;
    assign spi.AD_CONV = conv_q;
    assign busy        = (state_q != StIdle);
    assign ch0_data    = ch0_q;
    assign ch1_data    = ch1_q;
    assign data_valid  = dv_q;

endmodule

// File: tb/tb_amp_adc_reader.sv
// Bench for amp_adc_reader: three instances at CLK_DIV 2, 1 and 5 share one
// clock and reset, each with its own behavioural ADC.
module tb_amp_adc_reader;

    typedef struct {
        int          inst;
        logic [13:0] c0;
        logic [13:0] c1;
        longint      due;
    } exp_t;

    typedef struct {
        int          inst;
        logic [13:0] c0;
        logic [13:0] c1;
        bit          hz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_v = '0;
    logic [2:0]  sck_v, conv_v, busy_v, dv_v;
    logic [13:0] ch0_v [3];
    logic [13:0] ch1_v [3];
    logic [13:0] m0 [3];
    logic [13:0] m1 [3];
    bit          hz [3];
    longint      cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int div_of(int i);
        return (i == 0) ? 2 : (i == 1) ? 1 : 5;
    endfunction

    // ADC frame: counts 2..15 ch0 MSB first, 18..31 ch1 MSB first, rest hi-Z.
    function automatic logic adc_bit(int i, int k);
        if (k >= 2 && k <= 15) return m0[i][15-k];
        if (k >= 18 && k <= 31) return m1[i][31-k];
        return hz[i] ? logic'($urandom_range(1, 0)) : 1'b1;
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int unsigned Div = (gi == 0) ? 2 : (gi == 1) ? 1 : 5;
        amp_adc_reader_if u_if ();
        logic miso = 1'b1;
        int   idx = 0;

        amp_adc_reader #(.CLK_DIV(Div), .FRAME_BITS(34)) u_dut (
            .clock_in   (clk),
            .reset      (rst),
            .start      (start_v[gi]),
            .spi        (u_if),
            .busy       (busy_v[gi]),
            .ch0_data   (ch0_v[gi]),
            .ch1_data   (ch1_v[gi]),
            .data_valid (dv_v[gi])
        );

        assign u_if.SPI_MISO = miso;
        assign sck_v[gi]     = u_if.SPI_SCK;
        assign conv_v[gi]    = u_if.AD_CONV;

        // Present bit k on SCK rise k so it is stable at the sampling fall.
        always @(posedge u_if.SPI_SCK) begin
            if (u_if.AD_CONV) begin
                idx  <= 0;
                miso <= 1'b1;
            end else begin
                miso <= adc_bit(gi, idx);
                idx  <= idx + 1;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int i);
        start_v[i] = 1'b1;
        step();
        start_v[i] = 1'b0;
    endtask

    task automatic push_exp(input int i, input longint due_off);
        exp_t e;
        e.inst = i;
        e.c0   = m0[i];
        e.c1   = m1[i];
        e.due  = cyc + due_off;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int t = 0;
        while (sb.size() != 0 && t < budget) begin
            step();
            t++;
        end
        check("frame_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_zero(input int i, input string tag);
        check({tag, "_sck"}, sck_v[i], 0);
        check({tag, "_conv"}, conv_v[i], 0);
        check({tag, "_busy"}, busy_v[i], 0);
        check({tag, "_dv"}, dv_v[i], 0);
        check({tag, "_ch0"}, ch0_v[i], 0);
        check({tag, "_ch1"}, ch1_v[i], 0);
    endtask

    // Monitor: scoreboard on data_valid plus SCK/AD_CONV timing and data hold.
    initial begin
        int          hr [3];
        int          lr [3];
        int          cr [3];
        int          rises [3];
        logic        sp [3];
        logic        cp [3];
        logic        dp [3];
        logic [13:0] p0 [3];
        logic [13:0] p1 [3];
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            hr[i] = 0; lr[i] = 0; cr[i] = 0; rises[i] = 0;
            sp[i] = 0; cp[i] = 0; dp[i] = 0; p0[i] = '0; p1[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (rst) begin
                    hr[i] = 0; lr[i] = 0; cr[i] = 0; rises[i] = 0;
                    sp[i] = 0; cp[i] = 0; dp[i] = 0;
                    p0[i] = ch0_v[i]; p1[i] = ch1_v[i];
                    continue;
                end
                if (conv_v[i] && !cp[i]) rises[i] = 0;
                if (sck_v[i] && !sp[i]) begin
                    rises[i]++;
                    check("sck_low_len", lr[i], div_of(i));
                end
                if (sck_v[i]) begin
                    hr[i]++;
                    lr[i] = 0;
                end else begin
                    if (sp[i]) begin
                        check("sck_high_len", hr[i], div_of(i));
                        hr[i] = 0;
                    end
                    if (busy_v[i]) lr[i]++;
                    else lr[i] = 0;
                end
                if (conv_v[i]) cr[i]++;
                else if (cp[i]) begin
                    check("conv_high_len", cr[i], 2 * div_of(i));
                    cr[i] = 0;
                end
                if (dv_v[i]) begin
                    check("dv_width", dp[i], 0);
                    check("busy_at_dv", busy_v[i], 0);
                    check("sck_rises", rises[i], 35);
                    check("dv_expected", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("dv_inst", i, e.inst);
                        check("ch0_data", ch0_v[i], e.c0);
                        check("ch1_data", ch1_v[i], e.c1);
                        check("dv_cycle", cyc, e.due);
                    end
                end else begin
                    check("ch0_hold", ch0_v[i], p0[i]);
                    check("ch1_hold", ch1_v[i], p1[i]);
                end
                sp[i] = sck_v[i]; cp[i] = conv_v[i]; dp[i] = dv_v[i];
                p0[i] = ch0_v[i]; p1[i] = ch1_v[i];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs [6];
        logic [2:0] act;
        longint     n;

        vecs[0] = '{inst: 0, c0: 14'h2A5C, c1: 14'h1234, hz: 1'b0};
        vecs[1] = '{inst: 0, c0: 14'h2000, c1: 14'h1FFF, hz: 1'b1};
        vecs[2] = '{inst: 0, c0: 14'h3FFF, c1: 14'h0000, hz: 1'b1};
        vecs[3] = '{inst: 2, c0: 14'h2A5C, c1: 14'h1234, hz: 1'b0};
        vecs[4] = '{inst: 2, c0: 14'h1555, c1: 14'h2AAA, hz: 1'b1};
        vecs[5] = '{inst: 1, c0: 14'h0001, c1: 14'h3FFE, hz: 1'b1};
        for (int i = 0; i < 3; i++) begin
            m0[i] = '0; m1[i] = '0; hz[i] = 1'b0;
        end

        // Reset values, then a long idle with start low.
        rst = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        rst = 1'b0;
        act = '0;
        repeat (200) begin
            step();
            act |= sck_v | conv_v | busy_v | dv_v;
        end
        check("idle_activity", act, 0);
        check("idle_ch0", ch0_v[0], 0);

        // Single-frame vectors across dividers and data patterns.
        for (int v = 0; v < 6; v++) begin
            m0[vecs[v].inst] = vecs[v].c0;
            m1[vecs[v].inst] = vecs[v].c1;
            hz[vecs[v].inst] = vecs[v].hz;
            push_exp(vecs[v].inst, 1 + 70 * div_of(vecs[v].inst));
            pulse_start(vecs[v].inst);
            check("busy_after_start", busy_v[vecs[v].inst], 1);
            drain(70 * div_of(vecs[v].inst) + 20);
            repeat (5) step();
        end

        // start pulses while busy are ignored.
        m0[0] = 14'h0ABC; m1[0] = 14'h3123; hz[0] = 1'b1;
        push_exp(0, 141);
        pulse_start(0);
        repeat (20) step();
        pulse_start(0);
        repeat (60) step();
        pulse_start(0);
        drain(200);
        repeat (150) step();
        check("no_extra_frame", busy_v[0], 0);

        // start held high at CLK_DIV=1: three back-to-back frames 71 apart.
        m0[1] = 14'h2468; m1[1] = 14'h1357; hz[1] = 1'b1;
        push_exp(1, 71);
        push_exp(1, 142);
        push_exp(1, 213);
        start_v[1] = 1'b1;
        repeat (143) step();
        start_v[1] = 1'b0;
        drain(200);
        repeat (150) step();
        check("held_no_fourth", busy_v[1], 0);

        // Reset at bit count 20: abort, clear captured data, then recover.
        m0[0] = 14'h0F0F; m1[0] = 14'h30C3; hz[0] = 1'b1;
        n = cyc;
        pulse_start(0);
        repeat (84) step();
        check("pre_reset_cycle", cyc - n, 85);
        check("pre_reset_busy", busy_v[0], 1);
        rst = 1'b1;
        step();
        check_zero(0, "midreset");
        step();
        rst = 1'b0;
        repeat (200) step();
        check("post_reset_idle", busy_v[0], 0);
        m0[0] = 14'h1111; m1[0] = 14'h2E2E;
        push_exp(0, 141);
        pulse_start(0);
        drain(200);
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
